// File: rtl/controller.sv
// controller: sequential control unit for the single-cycle datapath.
// Decodes the opcode (instOut) and one-hot function field (funcOut) and drives
// every datapath strobe. A BOOT/IDLE/RUN/HALT state machine sequences PC reset,
// program start and halt.
// Optional feature: define CONTROLLER_RETIRE_CNT_EN to build the saturating
// retired-instruction counter; otherwise `retired` is tied to zero.
module controller #(
  parameter int unsigned BOOT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [3:0]  instOut,
  input  logic [7:0]  funcOut,
  output logic        rstPC,
  output logic        ldPC,
  output logic        pcSel,
  output logic        branchSel,
  output logic        jumpSel,
  output logic        regSel,
  output logic        inSel,
  output logic        selDm,
  output logic        selALU,
  output logic        regWrite,
  output logic        nop,
  output logic        ldWnd,
  output logic        memWrite,
  output logic        memRead,
  output logic [1:0]  wndCtrl,
  output logic [2:0]  funcCtrl,
  output logic        halted,
  output logic        illegal,
  output logic [15:0] retired
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    IDLE = 2'd1,
    RUN  = 2'd2,
    HALT = 2'd3
  } stateT;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_AND   = 3'b010;
  localparam logic [2:0] ALU_OR    = 3'b011;
  localparam logic [2:0] ALU_NOT   = 3'b100;
  localparam logic [2:0] ALU_PASS1 = 3'b101;

  localparam logic [3:0] BOOT_LAST = 4'(BOOT_CYCLES - 1);

  stateT      state;
  stateT      stateNext;
  logic [3:0] bootCnt;
  logic [3:0] bootCntNext;

  logic       instDefined;
  logic       instHalt;
  logic       rTypeOk;

  // Classify the current instruction: defined or not, and whether it is HALT.
  always_comb begin
    rTypeOk     = $onehot(funcOut) && !funcOut[7];
    instDefined = 1'b1;
    instHalt    = 1'b0;
    case (instOut)
      4'b0011, 4'b0101, 4'b0110: instDefined = 1'b0;
      4'b1000:                   instDefined = rTypeOk;
      4'b0111:                   instHalt    = 1'b1;
      default:                   instDefined = 1'b1;
    endcase
  end

  // State register and boot counter, synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= BOOT;
      bootCnt <= '0;
    end else begin
      state   <= stateNext;
      bootCnt <= bootCntNext;
    end
  end

  // Next-state logic; start is only looked at in IDLE.
  always_comb begin
    stateNext   = state;
    bootCntNext = bootCnt;
    case (state)
      BOOT: begin
        if (bootCnt == BOOT_LAST) begin
          stateNext   = IDLE;
          bootCntNext = '0;
        end else begin
          bootCntNext = bootCnt + 4'd1;
        end
      end
      IDLE: if (start) stateNext = RUN;
      RUN:  if (instHalt) stateNext = HALT;
      HALT: stateNext = HALT;
      default: stateNext = BOOT;
    endcase
  end

  // Output logic: strobes per state, combinational decode while in RUN.
  always_comb begin
    rstPC     = 1'b0;
    ldPC      = 1'b0;
    pcSel     = 1'b0;
    branchSel = 1'b0;
    jumpSel   = 1'b0;
    regSel    = 1'b0;
    inSel     = 1'b0;
    selDm     = 1'b0;
    selALU    = 1'b0;
    regWrite  = 1'b0;
    nop       = 1'b0;
    ldWnd     = 1'b0;
    memWrite  = 1'b0;
    memRead   = 1'b0;
    wndCtrl   = 2'b00;
    funcCtrl  = ALU_ADD;
    halted    = 1'b0;
    illegal   = 1'b0;
    case (state)
      BOOT: rstPC  = 1'b1;
      HALT: halted = 1'b1;
      RUN: begin
        ldPC  = 1'b1;
        pcSel = 1'b1;
        if (!instDefined) begin
          illegal = 1'b1;
        end else begin
          case (instOut)
            4'b0000: begin
              memRead  = 1'b1;
              selDm    = 1'b1;
              regWrite = 1'b1;
              nop      = 1'b1;
            end
            4'b0001: memWrite = 1'b1;
            4'b0010: jumpSel  = 1'b1;
            4'b0100: begin
              regSel    = 1'b1;
              funcCtrl  = ALU_SUB;
              branchSel = 1'b1;
            end
            4'b1000: begin
              regSel   = 1'b1;
              selALU   = 1'b1;
              regWrite = 1'b1;
              nop      = !funcOut[6];
              case (1'b1)
                funcOut[0]: funcCtrl = ALU_PASS1;
                funcOut[1]: funcCtrl = ALU_ADD;
                funcOut[2]: funcCtrl = ALU_SUB;
                funcOut[3]: funcCtrl = ALU_AND;
                funcOut[4]: funcCtrl = ALU_OR;
                funcOut[5]: funcCtrl = ALU_NOT;
                default:    funcCtrl = ALU_ADD;
              endcase
            end
            4'b1001, 4'b1010, 4'b1011: begin
              inSel    = 1'b1;
              selALU   = 1'b1;
              regWrite = 1'b1;
              nop      = 1'b1;
              case (instOut[1:0])
                2'b01:   funcCtrl = ALU_ADD;
                2'b10:   funcCtrl = ALU_SUB;
                default: funcCtrl = ALU_AND;
              endcase
            end
            4'b1100, 4'b1101, 4'b1110, 4'b1111: begin
              ldWnd   = 1'b1;
              wndCtrl = instOut[1:0];
            end
            4'b0111: ldPC = 1'b0;
            default: illegal = 1'b1;
          endcase
        end
      end
      default: ;
    endcase
  end

`ifdef CONTROLLER_RETIRE_CNT_EN
  logic [15:0] retiredCnt;

  // Saturating count of defined, non-HALT instructions committed in RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      retiredCnt <= '0;
    end else if (state == RUN && instDefined && !instHalt && retiredCnt != '1) begin
      retiredCnt <= retiredCnt + 16'd1;
    end
  end

  assign retired = retiredCnt;
`else
  assign retired = '0;
`endif

endmodule

// File: doc/controller.md
# controller

Sequential control unit sitting directly upstream of the single-cycle datapath. It decodes the opcode (`instOut`, ins[15:12]) and one-hot function field (`funcOut`, ins[7:0]) returned by the datapath, and drives every datapath control strobe. A boot/idle/run/halt state machine sequences PC reset, program start and halt. An optional retired-instruction counter supports bring-up.

## Interface
Parameters:
- `BOOT_CYCLES`, 2: number of cycles `rstPC` is held after reset; legal range 1..15.

Ports:
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: level; sampled only in IDLE.
- `instOut` in 4: opcode from the datapath.
- `funcOut` in 8: function field from the datapath.
- `rstPC`, `ldPC`, `pcSel`, `branchSel`, `jumpSel`, `regSel`, `inSel`, `selDm`, `selALU`, `regWrite`, `nop`, `ldWnd`, `memWrite`, `memRead` out 1: datapath strobes.
- `wndCtrl` out 2: register window to load.
- `funcCtrl` out 3: ALU op. ADD=000, SUB=001, AND=010, OR=011, NOT=100, PASS1=101.
- `halted` out 1: high in HALT.
- `illegal` out 1: high for one RUN cycle on an undefined instruction.
- `retired` out 16: retired-instruction count.

## Operation
- States: BOOT, IDLE, RUN, HALT. `rst` forces BOOT, clears the boot counter and clears `retired`.
- BOOT:
  - `rstPC`=1; every other output is 0.
  - After `BOOT_CYCLES` cycles, go to IDLE.
- IDLE:
  - All outputs are 0.
  - `start`=1 moves to RUN on the next edge.
- RUN: `ldPC`=1 and `pcSel`=1 every cycle. Decode is combinational from `instOut` and `funcOut`:
  - 0000 LOAD: `memRead`, `selDm`, `regWrite`, `nop`=1.
  - 0001 STORE: `memWrite`.
  - 0010 JUMP: `jumpSel`.
  - 0100 BZ: `regSel`, `funcCtrl`=SUB, `branchSel`. The datapath takes the branch when the two source registers are equal.
  - 1000 R-type: `regSel`, `selALU`, `regWrite`, `nop`=1. `funcOut` must be one-hot:
    - bit0 MOV: PASS1.
    - bit1 ADD, bit2 SUB, bit3 AND, bit4 OR, bit5 NOT.
    - bit6 NOP: forces `nop`=0, so no register write.
    - bit7: undefined.
  - 1001 ADDI, 1010 SUBI, 1011 ANDI: `inSel`, `selALU`, `regWrite`, `nop`=1, `funcCtrl` = ADD, SUB or AND respectively.
  - 11ww WIN: `ldWnd`=1, `wndCtrl`=ww.
  - 0111 HALT: `ldPC`=0, no writes. Next state is HALT.
  - Undefined instructions are opcodes 0011, 0101, 0110, and R-type whose `funcOut` is not one-hot or has bit7 set. They get no writes, the PC advances, and `illegal`=1.
- Outputs not listed for an instruction are 0. `wndCtrl`=0 except for WIN.
- HALT:
  - All outputs are 0 except `halted`=1. The PC therefore holds on the HALT instruction.
  - HALT exits only on `rst`.

## Timing
- Reset values: `rstPC`=1; all other outputs 0, including `retired`=0 and `halted`=0.
- BOOT-to-IDLE: `rstPC` is high for exactly `BOOT_CYCLES` cycles after `rst` deasserts.
- `start` sampled high in IDLE: first RUN cycle is the next cycle, executing the instruction at PC 0.
- `start` is ignored in BOOT, RUN and HALT.
- RUN decode has zero latency. Control is valid in the same cycle as `instOut`/`funcOut`, and the datapath commits at the next edge.
- HALT decoded at edge n: `halted`=1 from cycle n+1.
- `rst` asserted in any state, including mid-RUN, takes priority over every other condition and forces BOOT at that edge.
- `illegal` is high only during the offending RUN cycle.

## Configuration
- `CONTROLLER_RETIRE_CNT_EN` defined:
  - `retired` increments at each RUN edge whose instruction is defined and not HALT. NOP counts as retired.
  - The count saturates at 16'hFFFF and clears on `rst`.
- Undefined: `retired` is constantly 0 and the counter logic is not built.

## Test plan
- Reset with `BOOT_CYCLES`=2 → `rstPC`=1 for 2 cycles, then IDLE with all outputs 0. `start` pulsed → RUN next cycle with `ldPC`=1, `pcSel`=1.
- RUN, `instOut`=1000, `funcOut`=8'h02 → `funcCtrl`=000, `regSel`=`selALU`=`regWrite`=`nop`=1. Same with `funcOut`=8'h40 → `nop`=0.
- RUN, `instOut`=1101 → `ldWnd`=1, `wndCtrl`=01, `regWrite`=0.
- RUN, `instOut`=1000, `funcOut`=8'h06 → `illegal`=1 for one cycle, `ldPC`=1, no write strobes, `retired` unchanged (macro on).
- RUN, `instOut`=0111 → `ldPC`=0 that cycle, `halted`=1 next cycle. `start` toggling has no effect. `rst` → BOOT, `halted`=0.
- Macro on: 5 ADDI then HALT → `retired`=5. Preload near 16'hFFFF and retire extra instructions → stays 16'hFFFF. Macro off → `retired`=0 throughout.
